// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register; grant, load, release.
// Define SHARED_REG_TIMEOUT_EN to add the MAX_HOLD forced-release limit.
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        q,
  output logic [OW-1:0]           owner,
  output logic                    busy,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    COOL
  } state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_n;
  logic [WIDTH-1:0]  q_n;
  logic [OW-1:0]     owner_n;
  logic [OW-1:0]     last_owner, last_n;
  logic [OW-1:0]     win;
  logic              busy_n;
  logic              found;
  logic [WIDTH-1:0]  lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = wdata[i*WIDTH +: WIDTH];
  end

`ifdef SHARED_REG_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          tout_n;
  logic          limit;
  assign limit = (hold_cnt == HW'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  // Search starts just past the last owner, wrapping modulo NREQ.
  always_comb begin : arb
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    q_n     = q;
    owner_n = owner;
    busy_n  = busy;
    last_n  = last_owner;
`ifdef SHARED_REG_TIMEOUT_EN
    tout_n  = 1'b0;
    hold_n  = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n      = BUSY;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          owner_n      = win;
          busy_n       = 1'b1;
`ifdef SHARED_REG_TIMEOUT_EN
          hold_n       = '0;
`endif
        end
      end
      BUSY: begin
        if (req[owner]) begin
          q_n = lane[owner];
`ifdef SHARED_REG_TIMEOUT_EN
          hold_n = hold_cnt + 1'b1;
          // Final permitted load also releases the grant.
          if (limit) begin
            grant_n = '0;
            busy_n  = 1'b0;
            last_n  = owner;
            tout_n  = 1'b1;
            state_n = COOL;
          end
`endif
        end else begin
          grant_n = '0;
          busy_n  = 1'b0;
          last_n  = owner;
          state_n = COOL;
        end
      end
      COOL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      q          <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      last_owner <= OW'(NREQ - 1);
`ifdef SHARED_REG_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      q          <= q_n;
      owner      <= owner_n;
      busy       <= busy_n;
      last_owner <= last_n;
`ifdef SHARED_REG_TIMEOUT_EN
      hold_cnt   <= hold_n;
      timeout    <= tout_n;
`endif
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: vector table plus
// hand sequences for hold limit and mid-operation reset.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = 32'h44332211;

  shared_reg_arbiter #(
    .NREQ(4),
    .WIDTH(8),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wdata(wdata),
    .grant(grant),
    .q(q),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [7:0]  q;
    logic [1:0]  own;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic        r,
    input logic [3:0]  rq,
    input logic [31:0] wd,
    input logic [3:0]  g,
    input logic [7:0]  eq,
    input logic [1:0]  o,
    input logic        b
  );
    vec_t t;
    t.rst = r; t.req = rq; t.wd = wd;
    t.g = g; t.q = eq; t.own = o; t.bsy = b;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [31:0] wd);
    reset = r;
    req   = rq;
    wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    wdata = '0;

    // reset priority and round robin
    tbl.push_back(v(1, 4'b1111, BASE, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, BASE, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(v(0, 4'b1111, BASE, 4'b0001, 8'h00, 0, 1));
    tbl.push_back(v(0, 4'b1111, BASE, 4'b0001, 8'h11, 0, 1));
    tbl.push_back(v(0, 4'b1111, BASE, 4'b0001, 8'h11, 0, 1));
    tbl.push_back(v(0, 4'b1110, BASE, 4'b0000, 8'h11, 0, 0));
    tbl.push_back(v(0, 4'b1110, BASE, 4'b0000, 8'h11, 0, 0));
    tbl.push_back(v(0, 4'b1110, BASE, 4'b0010, 8'h11, 1, 1));
    tbl.push_back(v(0, 4'b1110, BASE, 4'b0010, 8'h22, 1, 1));
    tbl.push_back(v(0, 4'b1110, BASE, 4'b0010, 8'h22, 1, 1));
    tbl.push_back(v(0, 4'b1100, BASE, 4'b0000, 8'h22, 1, 0));
    tbl.push_back(v(0, 4'b1100, BASE, 4'b0000, 8'h22, 1, 0));
    tbl.push_back(v(0, 4'b1100, BASE, 4'b0100, 8'h22, 2, 1));
    tbl.push_back(v(0, 4'b1100, BASE, 4'b0100, 8'h33, 2, 1));
    tbl.push_back(v(0, 4'b1100, BASE, 4'b0100, 8'h33, 2, 1));
    tbl.push_back(v(0, 4'b1011, BASE, 4'b0000, 8'h33, 2, 0));
    tbl.push_back(v(0, 4'b1011, BASE, 4'b0000, 8'h33, 2, 0));
    tbl.push_back(v(0, 4'b1011, BASE, 4'b1000, 8'h33, 3, 1));
    tbl.push_back(v(0, 4'b1011, BASE, 4'b1000, 8'h44, 3, 1));
    tbl.push_back(v(0, 4'b1011, BASE, 4'b1000, 8'h44, 3, 1));
    tbl.push_back(v(0, 4'b0111, BASE, 4'b0000, 8'h44, 3, 0));
    tbl.push_back(v(0, 4'b0111, BASE, 4'b0000, 8'h44, 3, 0));
    tbl.push_back(v(0, 4'b0111, BASE, 4'b0001, 8'h44, 0, 1));
    // non-owner request ignored while owner holds
    tbl.push_back(v(0, 4'b0001, 32'h44332255, 4'b0001, 8'h55, 0, 1));
    tbl.push_back(v(0, 4'b0101, 32'h44AA2266, 4'b0001, 8'h66, 0, 1));
    tbl.push_back(v(0, 4'b0101, 32'h44AA2277, 4'b0001, 8'h77, 0, 1));
    tbl.push_back(v(0, 4'b0100, 32'h44AA2288, 4'b0000, 8'h77, 0, 0));
    tbl.push_back(v(0, 4'b0100, 32'h44AA2288, 4'b0000, 8'h77, 0, 0));
    tbl.push_back(v(0, 4'b0100, 32'h44AA2288, 4'b0100, 8'h77, 2, 1));
    // idle with no request keeps outputs
    tbl.push_back(v(0, 4'b0000, BASE, 4'b0000, 8'h77, 2, 0));
    tbl.push_back(v(0, 4'b0000, BASE, 4'b0000, 8'h77, 2, 0));
    tbl.push_back(v(0, 4'b0000, BASE, 4'b0000, 8'h77, 2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].wd);
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("v%0d q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].own));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'h0);
    end

`ifdef SHARED_REG_TIMEOUT_EN
    // forced release after MAX_HOLD loads; pending req3 wins next
    step(1, 4'b0000, 32'h0);
    step(0, 4'b1010, 32'h00000000);
    chk("fr grant", 32'(grant), 32'b0010);
    chk("fr owner", 32'(owner), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 4'b1010, 32'(k) << 8);
      chk($sformatf("fr q%0d", k), 32'(q), 32'(k));
      chk($sformatf("fr grant%0d", k), 32'(grant), 32'b0010);
      chk($sformatf("fr to%0d", k), 32'(timeout), 32'h0);
    end
    step(0, 4'b1010, 32'h00000400);
    chk("fr q4", 32'(q), 32'h04);
    chk("fr grant4", 32'(grant), 32'h0);
    chk("fr busy4", 32'(busy), 32'h0);
    chk("fr to4", 32'(timeout), 32'h1);
    step(0, 4'b1010, 32'h00000500);
    chk("fr cool q", 32'(q), 32'h04);
    chk("fr cool to", 32'(timeout), 32'h0);
    chk("fr cool grant", 32'(grant), 32'h0);
    step(0, 4'b1010, 32'h00000600);
    chk("fr next grant", 32'(grant), 32'b1000);
    chk("fr next owner", 32'(owner), 32'd3);
`else
    // no hold limit: owner keeps grant indefinitely
    step(1, 4'b0000, 32'h0);
    step(0, 4'b0010, 32'h00000000);
    chk("nh grant", 32'(grant), 32'b0010);
    for (int k = 1; k <= 20; k++) begin
      step(0, 4'b0010, 32'(k) << 8);
      chk($sformatf("nh q%0d", k), 32'(q), 32'(k));
      chk($sformatf("nh grant%0d", k), 32'(grant), 32'b0010);
      chk($sformatf("nh to%0d", k), 32'(timeout), 32'h0);
    end
`endif

    // reset while busy clears everything on that edge
    step(1, 4'b0000, 32'h0);
    step(0, 4'b0100, 32'h005C0000);
    chk("mr grant", 32'(grant), 32'b0100);
    step(0, 4'b0100, 32'h005C0000);
    chk("mr q", 32'(q), 32'h5C);
    chk("mr busy", 32'(busy), 32'h1);
    step(1, 4'b0100, 32'h00990000);
    chk("mr rst grant", 32'(grant), 32'h0);
    chk("mr rst q", 32'(q), 32'h0);
    chk("mr rst busy", 32'(busy), 32'h0);
    chk("mr rst owner", 32'(owner), 32'h0);
    step(0, 4'b1111, BASE);
    chk("mr prio grant", 32'(grant), 32'b0001);
    chk("mr prio owner", 32'(owner), 32'h0);
    step(0, 4'b1111, BASE);
    chk("mr prio q", 32'(q), 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and sequencer for a single shared, synchronously reset WIDTH-bit data register. It shares that register among NREQ requesters. Each requester gets exclusive, grant-gated write access for as long as it holds its request, with an optional hold limit. The block sits between multiple producer blocks and one common storage flop bank, and sequences grant, load and release.

## Interface
- NREQ, 4: number of requesters; range 2..16.
- WIDTH, 8: width of the shared register and of each requester's data.
- MAX_HOLD, 4: maximum consecutive load cycles per grant; range ≥1. Used only when the timeout feature is compiled in.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  NREQ  per-requester request, level.
- wdata  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  registered, one-hot or zero.
- q  output  WIDTH  shared register contents.
- owner  output  max(1,$clog2(NREQ))  index of the current/last grantee, registered.
- busy  output  1  high while in state BUSY.
- timeout  output  1  one-cycle pulse on forced release.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one requester owns the register.
  - COOL: one-cycle gap with grant=0.
- Reset:
  - State goes to IDLE.
  - grant, q, owner, busy, timeout, hold_cnt all go to 0.
  - Internal last_owner goes to NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req bit is 1, pick the first set bit searching last_owner+1, +2, … modulo NREQ (wrap-around).
  - Set grant to one-hot of the winner, set owner to the winner, set busy to 1, clear hold_cnt, go to BUSY.
  - If no req bit is set, stay in IDLE and leave all outputs unchanged.
- BUSY, with req[owner]=1:
  - q loads wdata[owner] and hold_cnt increments.
  - Requests from non-owners are ignored and remain pending.
- BUSY, with req[owner]=0:
  - No load; q holds its value.
  - grant goes to 0, busy goes to 0, last_owner is set to owner, go to COOL.
- COOL: always return to IDLE after one cycle; req is ignored.
- Forced release (feature enabled):
  - Condition: in BUSY with req[owner]=1 and hold_cnt==MAX_HOLD-1.
  - That edge performs the final load.
  - grant goes to 0, busy goes to 0, timeout goes to 1 for one cycle, last_owner is set to owner, go to COOL.
  - The preempted requester becomes lowest priority at the next arbitration.
- Simultaneous events:
  - reset overrides every other event.
  - If the owner drops req in the same cycle the hold limit would trigger, the release is normal: no load, timeout=0.
- Reset mid-operation: grant is removed on the same edge, and q is cleared even if a load was pending.
- q changes only on a reset edge or on a load edge.

## Timing
- Latency from req (sampled at edge N, arbiter in IDLE) to grant: grant is high after edge N.
- First load of q occurs at edge N+1 if req is still high.
- Release: owner drops req before edge M; grant is low after edge M.
- Earliest next grant is after edge M+2, due to one cycle in COOL and arbitration in IDLE.
- Maximum loads per grant with the feature enabled: MAX_HOLD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SHARED_REG_TIMEOUT_EN defined:
  - hold_cnt and the forced-release logic are present.
  - timeout pulses as described in Operation.
- SHARED_REG_TIMEOUT_EN undefined:
  - No hold limit; the owner keeps grant until it drops req.
  - timeout is tied to 0.
  - MAX_HOLD is ignored.
  - hold_cnt is removed.

## Test plan
All scenarios use NREQ=4, WIDTH=8, MAX_HOLD=4.
- Reset priority: reset for 2 cycles, then req=4'b1111 with wdata lanes 0x11/0x22/0x33/0x44 → all outputs 0 during reset; first grant=4'b0001, owner=0, q=0x11 after the first load.
- Round-robin order: hold req=4'b1111 and each grantee drops req after 2 loads → grant sequence 0001, 0010, 0100, 1000, 0001, with 2 idle-grant cycles between owners.
- Non-owner ignored: req0 granted, then req2 asserts with wdata2=0xAA → q keeps tracking wdata0 and grant stays 0001; after req0 drops, grant goes to 0100 two cycles later.
- Forced release (macro defined): req1 held high continuously with wdata1 incrementing 1,2,3,4,5 → exactly 4 loads, q=0x04, timeout pulses once and grant drops. If req3 is pending, the next grant goes to requester 3 before requester 1.
- No hold limit (macro undefined): repeat the forced-release scenario for 20 cycles → grant stays 0010, timeout stays 0, q tracks wdata1 every cycle.
- Mid-operation reset: reset asserted while BUSY with q=0x5C → grant=0, q=0, busy=0 after that edge; after reset is released, requester 0 again has first priority.
